btn_cmd_scheduler: RTL and testbench



---
 rtl/btn_cmd_scheduler.sv | 173 +++++++++++++++++
 tb/tb_btn_cmd_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : btn_cmd_scheduler
// Brief    : Debounces a push-button panel and serialises press requests onto
//            a valid/ready command port with round-robin arbitration.
// Revision : 1.0
// ============================================================================
module btn_cmd_scheduler #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int CNT_MAX = 100000,
    parameter int STABLE  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   btn,
    input  logic           cmd_ready,
    output logic           cmd_valid,
    output logic [IDW-1:0] cmd_id,
    output logic [N-1:0]   pending,
    output logic           overrun,
    output logic [N-1:0]   btn_level
);

    localparam int c_CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_tick;
    logic [N-1:0]       r_sync1;
    logic [N-1:0]       r_sync2;
    logic [STABLE-1:0]  r_hist [N];
    logic [STABLE-1:0]  w_shift [N];
    logic [N-1:0]       r_lvl;
    logic [N-1:0]       r_lvl_d;
    logic [N-1:0]       w_lvl_nxt;
    logic [N-1:0]       w_press;
    logic [N-1:0]       w_clr;
    logic [N-1:0]       r_pend;
    logic [N-1:0]       w_pend_nxt;
    logic               r_ovr;
    logic               w_accept;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [IDW-1:0]     r_cmd_id;
    logic [IDW-1:0]     w_id_nxt;
    logic [IDW-1:0]     r_grant;
    logic [IDW-1:0]     w_grant_nxt;
    logic [IDW-1:0]     w_sel;
    logic               w_found;

    assign w_tick   = (r_cnt == c_CNT_W'(CNT_MAX - 1));
    assign w_accept = r_valid & cmd_ready;
    assign w_press  = r_lvl & ~r_lvl_d;
    // A press wins over the clear of its own accepted command.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < N; i++) begin : g_deb
            assign w_shift[i]   = {r_hist[i][STABLE-2:0], r_sync2[i]};
            // Level follows the history including the sample taken this tick.
            assign w_lvl_nxt[i] = (w_tick && (&w_shift[i]))  ? 1'b1 :
                                  (w_tick && !(|w_shift[i])) ? 1'b0 : r_lvl[i];
            assign w_clr[i]     = w_accept && (r_cmd_id == IDW'(i));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            r_pend  <= '0;
            r_ovr   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_lvl   <= w_lvl_nxt;
            r_lvl_d <= r_lvl;
            r_pend  <= w_pend_nxt;
            r_ovr   <= |(w_press & r_pend & ~w_clr);
            if (w_tick) begin
                for (int i = 0; i < N; i++) begin
                    r_hist[i] <= w_shift[i];
                end
            end
        end
    end

    always_comb begin : arb_search
        int v_idx;
        v_idx   = 0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            v_idx = (int'(r_grant) + k) % N;
            if (!w_found && r_pend[v_idx]) begin
                w_found = 1'b1;
                w_sel   = IDW'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_id_nxt    = r_cmd_id;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_OFFER;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_sel;
                end
            end
            ST_OFFER: begin
                if (cmd_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_grant_nxt = r_cmd_id;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_cmd_id <= '0;
            r_grant  <= IDW'(N - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_cmd_id <= w_id_nxt;
            r_grant  <= w_grant_nxt;
        end
    end

    assign cmd_valid = r_valid;
    assign cmd_id    = r_cmd_id;
    assign pending   = r_pend;
    assign overrun   = r_ovr;
    assign btn_level = r_lvl;

endmodule
`default_nettype wire

// File: tb/tb_btn_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_cmd_scheduler
// Brief    : Directed self-checking bench for btn_cmd_scheduler with an
//            expected-command scoreboard.
// Revision : 1.0
// ============================================================================
module tb_btn_cmd_scheduler;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int CNT_MAX = 4;
    localparam int STABLE  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   btn = '0;
    logic           cmd_ready = 1'b0;
    logic           cmd_valid;
    logic [IDW-1:0] cmd_id;
    logic [N-1:0]   pending;
    logic           overrun;
    logic [N-1:0]   btn_level;

    btn_cmd_scheduler #(
        .N       (N),
        .IDW     (IDW),
        .CNT_MAX (CNT_MAX),
        .STABLE  (STABLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_id    (cmd_id),
        .pending   (pending),
        .overrun   (overrun),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int acc_cnt = 0;
    int ovr_cnt = 0;
    logic [IDW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_acc(input int target, input string tag);
        for (int i = 0; i < 300 && acc_cnt < target; i++) step(1);
        chk(tag, acc_cnt, target);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && cmd_valid !== 1'b1; i++) step(1);
        chk(tag, {31'd0, cmd_valid}, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, cmd_valid}, 0);
        chk({tag, "_id"}, {30'd0, cmd_id}, 0);
        chk({tag, "_pending"}, {28'd0, pending}, 0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 0);
        chk({tag, "_level"}, {28'd0, btn_level}, 0);
    endtask

    // Scoreboard consumer: samples after the bench drives, before the edge.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && cmd_valid && cmd_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) chk("unexpected_cmd", {30'd0, cmd_id}, 99);
            else chk("cmd_id", {30'd0, cmd_id}, {30'd0, exp_q.pop_front()});
        end
        if (rst_n && overrun) ovr_cnt++;
    end

    initial begin
        int a0;
        int o0;
        int seen;
        int bad;

        // Reset values and async reset during an offer
        #1;
        chk_all_zero("reset");
        step(3);
        rst_n = 1'b1;
        btn = 4'b1111;
        wait_valid("t1_offer");
        chk("t1_offer_id", {30'd0, cmd_id}, 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t1_async");
        step(2);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (cmd_valid !== 1'b0) seen = 1;
        end
        chk("t1_quiet_after_reset", seen, 0);
        a0 = acc_cnt;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        cmd_ready = 1'b1;
        wait_acc(a0 + 4, "t1_four_cmds");
        btn = 4'b0000;
        step(40);

        // Round robin from last_grant=3, then 3 again, then 1
        a0 = acc_cnt;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        btn = 4'b1011;
        wait_acc(a0 + 3, "t4_rr_013");
        btn = 4'b0000; step(40);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        btn = 4'b1001;
        wait_acc(a0 + 5, "t4_rr_03");
        btn = 4'b0000; step(40);
        exp_q.push_back(2'd1);
        btn = 4'b0010;
        wait_acc(a0 + 6, "t4_rr_1");
        btn = 4'b0000; step(40);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        btn = 4'b1001;
        wait_acc(a0 + 8, "t4_rr_30");
        btn = 4'b0000; step(40);

        // Single press with latency checks
        a0 = acc_cnt;
        btn = 4'b0100;
        for (int i = 0; i < 100 && btn_level[2] !== 1'b1; i++) step(1);
        chk("t2_level", {28'd0, btn_level}, 4'b0100);
        chk("t2_pend_pre", {28'd0, pending}, 0);
        exp_q.push_back(2'd2);
        step(1);
        chk("t2_pend_set", {28'd0, pending}, 4'b0100);
        chk("t2_valid_pre", {31'd0, cmd_valid}, 0);
        step(1);
        chk("t2_valid", {31'd0, cmd_valid}, 1);
        chk("t2_id", {30'd0, cmd_id}, 2);
        step(1);
        chk("t2_valid_post", {31'd0, cmd_valid}, 0);
        chk("t2_pend_clr", {28'd0, pending}, 0);
        step(40);
        chk("t2_single_cmd", acc_cnt, a0 + 1);
        btn = 4'b0000; step(40);

        // Glitch shorter than the stable window
        a0 = acc_cnt;
        btn = 4'b0010;
        step(8);
        btn = 4'b0000;
        step(40);
        chk("t3_level", {28'd0, btn_level}, 0);
        chk("t3_pending", {28'd0, pending}, 0);
        chk("t3_no_cmd", acc_cnt, a0);

        // Backpressure with overrun
        cmd_ready = 1'b0;
        a0 = acc_cnt;
        o0 = ovr_cnt;
        btn = 4'b0010;
        wait_valid("t5_offer");
        chk("t5_offer_id", {30'd0, cmd_id}, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) bad++;
        end
        btn = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) bad++;
        end
        btn = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (cmd_valid !== 1'b1 || cmd_id !== 2'd1) bad++;
        end
        chk("t5_stall_hold", bad, 0);
        chk("t5_overrun_once", ovr_cnt, o0 + 1);
        chk("t5_pending", {28'd0, pending}, 4'b0010);
        exp_q.push_back(2'd1);
        cmd_ready = 1'b1;
        wait_acc(a0 + 1, "t5_accept");
        step(2);
        chk("t5_pend_clr", {28'd0, pending}, 0);
        step(20);
        chk("t5_single_cmd", acc_cnt, a0 + 1);
        btn = 4'b0000; step(40);

        // Press coinciding with the accept of its own command
        cmd_ready = 1'b0;
        a0 = acc_cnt;
        o0 = ovr_cnt;
        btn = 4'b0100;
        wait_valid("t6_offer");
        chk("t6_offer_id", {30'd0, cmd_id}, 2);
        exp_q.push_back(2'd2);
        btn = 4'b0000;
        step(40);
        btn = 4'b0100;
        for (int i = 0; i < 100 && btn_level[2] !== 1'b1; i++) step(1);
        chk("t6_level", {28'd0, btn_level}, 4'b0100);
        exp_q.push_back(2'd2);
        cmd_ready = 1'b1;
        step(1);
        chk("t6_pend_kept", {28'd0, pending}, 4'b0100);
        wait_acc(a0 + 2, "t6_second_cmd");
        step(3);
        chk("t6_pend_clr", {28'd0, pending}, 0);
        chk("t6_no_overrun", ovr_cnt, o0);
        btn = 4'b0000; step(40);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
